// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word type, sigma/choice/majority helpers,
// round constants and initial hash values. Used by the message schedule
// and by the compression round engine.
package sha256_pkg;

   typedef logic [31:0] word_t;

   // Controller state shared by all schedule lanes.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } sched_state_t;

   // Small sigma 0: ROTR7 ^ ROTR18 ^ SHR3
   function automatic word_t ssig0(input word_t x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   // Small sigma 1: ROTR17 ^ ROTR19 ^ SHR10
   function automatic word_t ssig1(input word_t x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // Big sigma 0: ROTR2 ^ ROTR13 ^ ROTR22
   function automatic word_t bsig0(input word_t x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   // Big sigma 1: ROTR6 ^ ROTR11 ^ ROTR25
   function automatic word_t bsig1(input word_t x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic word_t ch(input word_t x, input word_t y, input word_t z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic word_t maj(input word_t x, input word_t y, input word_t z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   // Round constants K[0..63]
   localparam word_t K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // Initial hash value H(0)
   localparam word_t H0 [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Load and word-stream handshake bundle of the message schedule.
// master: block/nonce builder plus round-engine side; slave: the schedule.
interface sha256_msg_schedule_if #(
   parameter int LANES = 1
);
   logic                    load_valid;
   logic                    load_ready;
   logic [LANES*512-1:0]    block_in;
   logic                    w_valid;
   logic                    w_ready;
   logic [LANES*32-1:0]     w_word;
   logic [5:0]              w_index;
   logic                    w_last;

   modport master (
      output load_valid, block_in, w_ready,
      input  load_ready, w_valid, w_word, w_index, w_last
   );

   modport slave (
      input  load_valid, block_in, w_ready,
      output load_ready, w_valid, w_word, w_index, w_last
   );
endinterface

// File: rtl/sha256_sched_lane.sv
// One lane of the message schedule: a 16-word sliding window that is
// parallel-loaded from a 512-bit block and then shifts by one word per
// accepted beat, appending the next expanded word at the top.
module sha256_sched_lane
   import sha256_pkg::*;
#(
   parameter int LSW_FIRST = 0
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic [511:0] block_i,
   output word_t        word_o
);

   word_t win_q  [16];
   word_t win_d  [16];
   word_t load_w [16];
   word_t new_w;

   // Block-to-window word mapping; the ordering is fixed at elaboration.
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_load
         if (LSW_FIRST != 0) begin : g_lsw
            assign load_w[gi] = block_i[gi*32 +: 32];
         end else begin : g_msw
            assign load_w[gi] = block_i[(15-gi)*32 +: 32];
         end
      end
   endgenerate

   // Window slot 0 is W[t], so slots 14/9/1/0 are W[t+14]/W[t+9]/W[t+1]/W[t],
   // which is exactly the recurrence for W[t+16]. Computed on every shift.
   assign new_w = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];

   // Next window: parallel load wins over shift, otherwise hold.
   always_comb begin
      win_d = win_q;
      if (load_i) begin
         win_d = load_w;
      end else if (shift_i) begin
         for (int k = 0; k < 15; k++) begin
            win_d[k] = win_q[k+1];
         end
         win_d[15] = new_w;
      end
   end

   // Window storage, cleared on reset.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int k = 0; k < 16; k++) begin
            win_q[k] <= '0;
         end
      end else begin
         win_q <= win_d;
      end
   end

   assign word_o = win_q[0];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander. One shared controller (state, round
// counter, handshakes) drives LANES data-only window lanes in lockstep.
module sha256_msg_schedule
   import sha256_pkg::*;
#(
   parameter int LANES     = 1,
   parameter int ROUNDS    = 64,
   parameter int LSW_FIRST = 0
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 abort,
   sha256_msg_schedule_if.slave bus,
   output logic                 busy
);

   localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

   sched_state_t         state_q, state_d;
   logic [5:0]           t_q, t_d;
   logic                 load_en;
   logic                 shift_en;
   logic [LANES*32-1:0]  lane_words;

   // Controller state and round counter.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ST_IDLE;
         t_q     <= '0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
      end
   end

   // Next state, counter and lane enables; abort overrides everything.
   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      load_en  = 1'b0;
      shift_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            t_d = '0;
            if (bus.load_valid) begin
               load_en = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.w_ready) begin
               shift_en = 1'b1;
               if (t_q == LAST_T) begin
                  state_d = ST_IDLE;
                  t_d     = '0;
               end else begin
                  t_d = t_q + 6'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            t_d     = '0;
         end
      endcase
      if (abort) begin
         state_d  = ST_IDLE;
         t_d      = '0;
         load_en  = 1'b0;
         shift_en = 1'b0;
      end
   end

   // Per-lane windows; each lane sees its own 512-bit slice of the block.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         sha256_sched_lane #(
            .LSW_FIRST (LSW_FIRST)
         ) u_lane (
            .clk     (clk),
            .n_rst   (n_rst),
            .load_i  (load_en),
            .shift_i (shift_en),
            .block_i (bus.block_in[gi*512 +: 512]),
            .word_o  (lane_words[gi*32 +: 32])
         );
      end
   endgenerate

   // All outputs come straight from registers or a decode of them.
   assign bus.load_ready = (state_q == ST_IDLE);
   assign bus.w_valid    = (state_q == ST_RUN);
   assign bus.w_word     = lane_words;
   assign bus.w_index    = t_q;
   assign bus.w_last     = (state_q == ST_RUN) && (t_q == LAST_T);
   assign busy           = (state_q == ST_RUN);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for the SHA-256 message schedule: a 4-lane FIPS-order 64-round
// instance and a 1-lane LSW-first 16-round instance, checked against a
// full-array FIPS 180-4 schedule model.
module tb_sha256_msg_schedule;

   localparam int A_LANES  = 4;
   localparam int A_ROUNDS = 64;
   localparam int B_ROUNDS = 16;

   logic clk     = 1'b0;
   logic n_rst   = 1'b0;
   logic a_abort = 1'b0;
   logic b_abort = 1'b0;
   logic a_busy;
   logic b_busy;
   int   checks  = 0;
   int   errors  = 0;

   always #5 clk = ~clk;

   sha256_msg_schedule_if #(.LANES(A_LANES)) a_if ();
   sha256_msg_schedule_if #(.LANES(1))       b_if ();

   sha256_msg_schedule #(
      .LANES(A_LANES), .ROUNDS(A_ROUNDS), .LSW_FIRST(0)
   ) dut_a (
      .clk(clk), .n_rst(n_rst), .abort(a_abort), .bus(a_if), .busy(a_busy)
   );

   sha256_msg_schedule #(
      .LANES(1), .ROUNDS(B_ROUNDS), .LSW_FIRST(1)
   ) dut_b (
      .clk(clk), .n_rst(n_rst), .abort(b_abort), .bus(b_if), .busy(b_busy)
   );

   // ---------------- reference model ----------------
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] m_s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] m_s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   // Full 64-entry schedule of one block; returns W[t].
   function automatic logic [31:0] ref_w(input logic [511:0] blk, input bit lsw, input int t);
      logic [31:0] w [64];
      for (int i = 0; i < 64; i++) begin
         if (i < 16) w[i] = lsw ? blk[i*32 +: 32] : blk[(15-i)*32 +: 32];
         else        w[i] = m_s1(w[i-2]) + w[i-7] + m_s0(w[i-15]) + w[i-16];
      end
      return w[t];
   endfunction

   // Published first words of the schedule of the padded "abc" block.
   function automatic logic [31:0] abc_exp(input int t);
      case (t)
         0:       return 32'h61626380;
         15:      return 32'h00000018;
         16:      return 32'h61626380;
         17:      return 32'h000f0000;
         default: return 32'h00000000;
      endcase
   endfunction

   function automatic logic [A_LANES*512-1:0] rnd_a();
      logic [A_LANES*512-1:0] r;
      for (int i = 0; i < A_LANES*16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [511:0] rnd_b();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One block on dut_a. act: 0 run to end, 1 abort at stop_at, 2 reset at stop_at.
   // hold_lv keeps load_valid high during RUN with block_in switched to nxt.
   task automatic run_a(input logic [A_LANES*512-1:0] blk, input logic [A_LANES*512-1:0] nxt,
                        input int pct, input int stop_at, input int act, input bit hold_lv,
                        input bit abc, input string name);
      logic [127:0] expw;
      int t;
      int cyc;
      bit rdy;
      chk({name, ":load_ready_idle"}, a_if.load_ready, 1);
      a_if.block_in   = blk;
      a_if.load_valid = 1'b1;
      a_if.w_ready    = 1'b0;
      @(negedge clk);
      if (hold_lv) a_if.block_in = nxt;
      else         a_if.load_valid = 1'b0;
      t   = 0;
      cyc = 0;
      while (t < A_ROUNDS && cyc < 2000) begin
         expw = '0;
         for (int l = 0; l < A_LANES; l++) expw[l*32 +: 32] = ref_w(blk[l*512 +: 512], 1'b0, t);
         chk({name, ":w_valid"},    a_if.w_valid, 1);
         chk({name, ":w_index"},    a_if.w_index, 128'(t));
         chk({name, ":w_word"},     a_if.w_word, expw);
         chk({name, ":w_last"},     a_if.w_last, 128'(t == A_ROUNDS - 1));
         chk({name, ":load_ready"}, a_if.load_ready, 0);
         chk({name, ":busy"},       a_busy, 1);
         if (abc && t < 18) chk({name, ":abc_word"}, a_if.w_word[31:0], abc_exp(t));
         if (act != 0 && t == stop_at) break;
         rdy = ($urandom_range(0, 99) < pct);
         a_if.w_ready = rdy;
         @(negedge clk);
         cyc++;
         if (rdy) t++;
      end
      if (act == 1) begin
         a_if.w_ready = 1'b1;
         a_abort      = 1'b1;
         @(negedge clk);
         a_abort      = 1'b0;
         a_if.w_ready = 1'b0;
         if (hold_lv) a_if.load_valid = 1'b0;
         chk({name, ":abort_w_valid"},    a_if.w_valid, 0);
         chk({name, ":abort_load_ready"}, a_if.load_ready, 1);
         chk({name, ":abort_w_index"},    a_if.w_index, 0);
         chk({name, ":abort_busy"},       a_busy, 0);
      end else if (act == 2) begin
         a_if.w_ready = 1'b1;
         @(posedge clk);
         #2;
         n_rst = 1'b0;
         #1;
         chk({name, ":rst_load_ready"}, a_if.load_ready, 1);
         chk({name, ":rst_w_valid"},    a_if.w_valid, 0);
         chk({name, ":rst_w_word"},     a_if.w_word, 0);
         chk({name, ":rst_w_index"},    a_if.w_index, 0);
         chk({name, ":rst_w_last"},     a_if.w_last, 0);
         chk({name, ":rst_busy"},       a_busy, 0);
         @(negedge clk);
         a_if.w_ready = 1'b0;
         n_rst = 1'b1;
      end else begin
         a_if.w_ready = 1'b0;
         chk({name, ":beats"},        t, A_ROUNDS);
         chk({name, ":end_w_valid"},  a_if.w_valid, 0);
         chk({name, ":end_ready"},    a_if.load_ready, 1);
         chk({name, ":end_w_last"},   a_if.w_last, 0);
         chk({name, ":end_busy"},     a_busy, 0);
      end
      $display("block %s lanes=%0d beats=%0d cycles=%0d", name, A_LANES, t, cyc);
   endtask

   // One block on dut_b (LSW-first packing, 16 rounds).
   task automatic run_b(input logic [511:0] blk, input int pct, input string name);
      int t;
      int cyc;
      bit rdy;
      chk({name, ":load_ready_idle"}, b_if.load_ready, 1);
      b_if.block_in   = blk;
      b_if.load_valid = 1'b1;
      b_if.w_ready    = 1'b0;
      @(negedge clk);
      b_if.load_valid = 1'b0;
      t   = 0;
      cyc = 0;
      while (t < B_ROUNDS && cyc < 500) begin
         chk({name, ":w_valid"}, b_if.w_valid, 1);
         chk({name, ":w_index"}, b_if.w_index, 128'(t));
         chk({name, ":w_word"},  b_if.w_word, ref_w(blk, 1'b1, t));
         chk({name, ":raw"},     b_if.w_word, blk[t*32 +: 32]);
         chk({name, ":w_last"},  b_if.w_last, 128'(t == B_ROUNDS - 1));
         if (t == 0 && blk[31:0] == 32'h61626380) chk({name, ":w0_abc"}, b_if.w_word, 32'h61626380);
         rdy = ($urandom_range(0, 99) < pct);
         b_if.w_ready = rdy;
         @(negedge clk);
         cyc++;
         if (rdy) t++;
      end
      b_if.w_ready = 1'b0;
      chk({name, ":beats"},       t, B_ROUNDS);
      chk({name, ":end_w_valid"}, b_if.w_valid, 0);
      chk({name, ":end_ready"},   b_if.load_ready, 1);
      chk({name, ":end_busy"},    b_busy, 0);
      $display("block %s lanes=1 beats=%0d cycles=%0d", name, t, cyc);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [A_LANES*512-1:0] blk;
      logic [A_LANES*512-1:0] nxt;
      logic [511:0]           bblk;

      a_if.load_valid = 1'b0;
      a_if.block_in   = '0;
      a_if.w_ready    = 1'b0;
      b_if.load_valid = 1'b0;
      b_if.block_in   = '0;
      b_if.w_ready    = 1'b0;

      repeat (3) @(negedge clk);
      chk("reset:load_ready", a_if.load_ready, 1);
      chk("reset:w_valid",    a_if.w_valid, 0);
      chk("reset:w_word",     a_if.w_word, 0);
      chk("reset:w_index",    a_if.w_index, 0);
      chk("reset:w_last",     a_if.w_last, 0);
      chk("reset:busy",       a_busy, 0);
      chk("reset:b_w_valid",  b_if.w_valid, 0);
      n_rst = 1'b1;
      @(negedge clk);

      // "abc" in lane 0, random data in the other lanes, no back-pressure
      blk = rnd_a();
      blk[511:0] = {32'h61626380, 448'h0, 32'h00000018};
      run_a(blk, '0, 100, -1, 0, 1'b0, 1'b1, "abc");

      // random blocks with 50% back-pressure
      for (int i = 0; i < 3; i++) run_a(rnd_a(), '0, 50, -1, 0, 1'b0, 1'b0, "rand50");

      // abort together with a load request in IDLE drops the load
      a_abort         = 1'b1;
      a_if.load_valid = 1'b1;
      a_if.block_in   = rnd_a();
      @(negedge clk);
      a_abort         = 1'b0;
      a_if.load_valid = 1'b0;
      chk("idle_abort:w_valid",    a_if.w_valid, 0);
      chk("idle_abort:load_ready", a_if.load_ready, 1);
      @(negedge clk);
      chk("idle_abort:still_idle", a_if.w_valid, 0);

      // abort at t=30, then a clean block restarts at W0
      run_a(rnd_a(), '0, 100, 30, 1, 1'b0, 1'b0, "abort30");
      run_a(rnd_a(), '0, 60, -1, 0, 1'b0, 1'b0, "after_abort");

      // load_valid held through RUN with new data: no re-capture, then the
      // next block is taken right after the dead cycle
      nxt = rnd_a();
      run_a(rnd_a(), nxt, 50, -1, 0, 1'b1, 1'b0, "hold_lv");
      run_a(nxt, '0, 100, -1, 0, 1'b0, 1'b0, "recapture");

      // reset at t=40 with load_valid held; exactly one block after release
      nxt = rnd_a();
      run_a(rnd_a(), nxt, 100, 40, 2, 1'b1, 1'b0, "reset40");
      run_a(nxt, '0, 70, -1, 0, 1'b0, 1'b0, "post_reset");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_extra_block", a_if.w_valid, 0);
      end

      // 16-round LSW-first instance
      bblk = rnd_b();
      bblk[31:0] = 32'h61626380;
      run_b(bblk, 100, "lsw_abc");
      run_b(rnd_b(), 50, "lsw_rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
